// File: rtl/snake_body_engine.sv
// Snake game-state engine: moves the head on each step tick, detects wall and
// self collisions, grows on food, and keeps body cells in a circular buffer.
module snake_body_engine #(
    parameter  int GRID_W   = 16,
    parameter  int GRID_H   = 12,
    parameter  int MAX_LEN  = 64,
    parameter  int INIT_X   = 4,
    parameter  int INIT_Y   = 6,
    parameter  int INIT_LEN = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int IW = $clog2(MAX_LEN),
    localparam int LW = IW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_en,
    input  logic [1:0]    forward,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    input  logic [IW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          step_done,
    output logic          food_eaten,
    output logic          game_over
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CALC, S_SCAN, S_COMMIT, S_DEAD
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     head_ptr_q, head_ptr_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     lim_q, lim_d;
    logic [LW-1:0]     length_q, length_d;
    logic [XW-1:0]     head_x_q, head_x_d;
    logic [YW-1:0]     head_y_q, head_y_d;
    logic [1:0]        fwd_q, fwd_d;
    logic [XW-1:0]     food_x_q, food_x_d;
    logic [YW-1:0]     food_y_q, food_y_d;
    logic              grow_q, grow_d;
    logic              eat_q, eat_d;
    logic              step_done_q, step_done_d;
    logic              food_eaten_q, food_eaten_d;
    logic [XW-1:0]     rd_x_q, rd_x_d;
    logic [YW-1:0]     rd_y_q, rd_y_d;
    logic              rd_valid_q, rd_valid_d;

    logic [XW+YW-1:0]  mem_q [MAX_LEN];
    logic              we;
    logic [IW-1:0]     waddr;
    logic [XW+YW-1:0]  wdata;

    logic [XW-1:0]     nxt_x;
    logic [YW-1:0]     nxt_y;
    logic              wall;
    logic              hit;
    logic              eat_c;
    logic              grow_c;
    logic [LW-1:0]     lim_c;

    // Candidate head position and wall test from the latched direction.
    always_comb begin
        nxt_x = head_x_q;
        nxt_y = head_y_q;
        wall  = 1'b0;
        case (fwd_q)
            2'b00: begin wall = (head_x_q == XW'(GRID_W - 1)); nxt_x = head_x_q + XW'(1); end
            2'b01: begin wall = (head_x_q == '0);              nxt_x = head_x_q - XW'(1); end
            2'b10: begin wall = (head_y_q == YW'(GRID_H - 1)); nxt_y = head_y_q + YW'(1); end
            default: begin wall = (head_y_q == '0);            nxt_y = head_y_q - YW'(1); end
        endcase
        hit    = (mem_q[head_ptr_q - idx_q[IW-1:0]] == {nxt_x, nxt_y});
        eat_c  = ({nxt_x, nxt_y} == {food_x_q, food_y_q});
        grow_c = eat_c && (length_q < LW'(MAX_LEN));
        // A non-growing step vacates the tail, so the head may move into it.
        lim_c  = grow_c ? length_q : length_q - LW'(1);
    end

    always_comb begin
        state_d      = state_q;
        head_ptr_d   = head_ptr_q;
        idx_d        = idx_q;
        lim_d        = lim_q;
        length_d     = length_q;
        head_x_d     = head_x_q;
        head_y_d     = head_y_q;
        fwd_d        = fwd_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        grow_d       = grow_q;
        eat_d        = eat_q;
        step_done_d  = 1'b0;
        food_eaten_d = 1'b0;
        we           = 1'b0;
        waddr        = head_ptr_q;
        wdata        = {nxt_x, nxt_y};
        rd_x_d       = mem_q[head_ptr_q - rd_idx][XW+YW-1:YW];
        rd_y_d       = mem_q[head_ptr_q - rd_idx][YW-1:0];
        rd_valid_d   = ({1'b0, rd_idx} < length_q);
        case (state_q)
            S_INIT: begin
                we    = 1'b1;
                waddr = IW'(0) - idx_q[IW-1:0];
                wdata = {XW'(INIT_X) - XW'(idx_q), YW'(INIT_Y)};
                if (idx_q == LW'(INIT_LEN - 1)) begin
                    idx_d    = '0;
                    length_d = LW'(INIT_LEN);
                    head_x_d = XW'(INIT_X);
                    head_y_d = YW'(INIT_Y);
                    state_d  = S_IDLE;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            S_IDLE: begin
                if (step_en) begin
                    fwd_d    = forward;
                    food_x_d = food_x;
                    food_y_d = food_y;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (wall) begin
                    state_d = S_DEAD;
                end else begin
                    eat_d   = eat_c;
                    grow_d  = grow_c;
                    lim_d   = lim_c;
                    idx_d   = '0;
                    state_d = (lim_c == '0) ? S_COMMIT : S_SCAN;
                end
            end
            S_SCAN: begin
                idx_d = idx_q + LW'(1);
                if (hit) begin
                    state_d = S_DEAD;
                end else if (idx_q + LW'(1) == lim_q) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                head_ptr_d   = head_ptr_q + IW'(1);
                we           = 1'b1;
                waddr        = head_ptr_q + IW'(1);
                head_x_d     = nxt_x;
                head_y_d     = nxt_y;
                length_d     = length_q + LW'(grow_q);
                step_done_d  = 1'b1;
                food_eaten_d = eat_q;
                state_d      = S_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            head_ptr_q   <= '0;
            idx_q        <= '0;
            length_q     <= '0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            step_done_q  <= 1'b0;
            food_eaten_q <= 1'b0;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_ptr_q   <= head_ptr_d;
            idx_q        <= idx_d;
            length_q     <= length_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            step_done_q  <= step_done_d;
            food_eaten_q <= food_eaten_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Step operands are always rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        lim_q    <= lim_d;
        fwd_q    <= fwd_d;
        food_x_q <= food_x_d;
        food_y_q <= food_y_d;
        grow_q   <= grow_d;
        eat_q    <= eat_d;
        if (we && !rst) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_valid   = rd_valid_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign length     = length_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DEAD);
    assign step_done  = step_done_q;
    assign food_eaten = food_eaten_q;
    assign game_over  = (state_q == S_DEAD);

endmodule
